// File: rtl/lzx_cs_arbiter8.sv
// Round-robin chip-select scheduler driving one 3-to-8 decoder for 8 requesters.
// Optional `LZX_CS_ARB_LOCK_EN adds a lock input that stretches a grant past HOLD_MAX.
module lzx_cs_arbiter8 #(
  parameter int HOLD_MAX  = 4,
  parameter int SETUP_CYC = 1,
  parameter int GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef LZX_CS_ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [7:0] req,
  output logic       E1_n,
  output logic       E2_n,
  output logic       E3,
  output logic [2:0] A,
  output logic [7:0] gnt_n,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_GUARD} state_t;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_n_q, gnt_n_d;
  logic       en_act_q, en_act_d;
  logic       busy_q, busy_d;

  logic [7:0] rot;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       req_a;
  logic       lock_on;
  logic [7:0] hold_inc;
  logic       limit_hit;

`ifdef LZX_CS_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // rot[i] is the request of the requester i places after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot[gi] = req[ptr_q + 3'(gi)];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) win_off = 3'(i);
    end
  end

  assign win_idx   = ptr_q + win_off;
  assign req_a     = req[a_q];
  // Hold counter saturates so a locked grant cannot wrap it
  assign hold_inc  = (cnt_q >= 8'(HOLD_MAX)) ? cnt_q : cnt_q + 8'd1;
  assign limit_hit = (hold_inc >= 8'(HOLD_MAX));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_n_d  = gnt_n_q;
    en_act_d = en_act_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (en && (req != 8'd0)) begin
          a_d     = win_idx;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!req_a) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(SETUP_CYC - 1)) begin
          state_d  = S_ACTIVE;
          en_act_d = 1'b1;
          gnt_n_d  = ~(8'b1 << a_q);
          cnt_d    = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACTIVE: begin
        if (!req_a || (limit_hit && !lock_on)) begin
          state_d  = S_GUARD;
          en_act_d = 1'b0;
          gnt_n_d  = 8'hFF;
          ptr_d    = a_q + 3'd1;
          cnt_d    = 8'd0;
        end else begin
          cnt_d = hold_inc;
        end
      end
      S_GUARD: begin
        if (cnt_q == 8'(GUARD_CYC - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        en_act_d = 1'b0;
        gnt_n_d  = 8'hFF;
        busy_d   = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 3'd0;
      ptr_q    <= 3'd0;
      cnt_q    <= 8'd0;
      gnt_n_q  <= 8'hFF;
      en_act_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_n_q  <= gnt_n_d;
      en_act_q <= en_act_d;
      busy_q   <= busy_d;
    end
  end

  // All three decoder enables move together from one flop
  assign E1_n  = ~en_act_q;
  assign E2_n  = ~en_act_q;
  assign E3    = en_act_q;
  assign A     = a_q;
  assign gnt_n = gnt_n_q;
  assign busy  = busy_q;

endmodule
